// File: rtl/game_screen_controller.sv
// Screen sequencer TITLE -> PLAY -> OVER with frame-aligned mode changes and game pacing ticks.
// Optional pause mode: define GAME_PAUSE_EN.
module game_screen_controller #(
    parameter int H_ACTIVE    = 640,
    parameter int V_ACTIVE    = 480,
    parameter int TICK_FRAMES = 8,
    parameter int OVER_FRAMES = 120
) (
    input  logic       clock_25,
    input  logic       KEY,
    input  logic [9:0] X,
    input  logic [9:0] Y,
    input  logic       start_btn,
    input  logic       game_over,
    input  logic [1:0] game_color,
    output logic       game_enable,
    output logic [1:0] color_data,
    output logic       frame_tick,
    output logic       game_tick,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        S_TITLE = 2'b00,
        S_PLAY  = 2'b01,
        S_OVER  = 2'b10,
        S_PAUSE = 2'b11
    } state_t;

    localparam int TCW = (TICK_FRAMES > 1) ? $clog2(TICK_FRAMES) : 1;
    localparam int OCW = (OVER_FRAMES > 1) ? $clog2(OVER_FRAMES) : 1;
    localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_FRAMES - 1);
    localparam logic [OCW-1:0] OVER_LAST = OCW'(OVER_FRAMES - 1);
    localparam logic [9:0] X_LAST = 10'(H_ACTIVE - 1);
    localparam logic [9:0] Y_LAST = 10'(V_ACTIVE - 1);

    state_t         state_q;
    state_t         state_d;
    logic           btn_s1;
    logic           btn_s2;
    logic           btn_prev;
    logic           btn_fall;
    logic           start_pend;
    logic           over_pend;
    logic [TCW-1:0] tick_cnt;
    logic [OCW-1:0] over_cnt;
    logic [1:0]     color_q;
    logic           in_game;
    logic           stay_play;

    // Idle level of the button is high, so the synchroniser resets high
    always_ff @(posedge clock_25 or negedge KEY) begin
        if (!KEY) begin
            btn_s1   <= 1'b1;
            btn_s2   <= 1'b1;
            btn_prev <= 1'b1;
        end else begin
            btn_s1   <= start_btn;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
        end
    end

    assign btn_fall  = btn_prev & ~btn_s2;
    assign in_game   = (state_q == S_PLAY) || (state_q == S_PAUSE);
    assign stay_play = (state_q == S_PLAY) && (state_d == S_PLAY);

    always_comb begin
        state_d = state_q;
        if (frame_tick) begin
            unique case (state_q)
                S_TITLE: begin
                    if (start_pend) state_d = S_PLAY;
                end
                S_PLAY: begin
                    if (over_pend) state_d = S_OVER;
`ifdef GAME_PAUSE_EN
                    else if (start_pend) state_d = S_PAUSE;
`endif
                end
                S_OVER: begin
                    if (over_cnt == OVER_LAST) state_d = S_TITLE;
                end
                S_PAUSE: begin
                    if (over_pend) state_d = S_OVER;
                    else if (start_pend) state_d = S_PLAY;
                end
                default: state_d = S_TITLE;
            endcase
        end
    end

    always_ff @(posedge clock_25 or negedge KEY) begin
        if (!KEY) begin
            state_q     <= S_TITLE;
            frame_tick  <= 1'b0;
            start_pend  <= 1'b0;
            over_pend   <= 1'b0;
            tick_cnt    <= '0;
            over_cnt    <= '0;
            game_enable <= 1'b0;
            color_q     <= 2'b00;
        end else begin
            state_q     <= state_d;
            frame_tick  <= (X == X_LAST) && (Y == Y_LAST);
            game_enable <= (state_d == S_PLAY) || (state_d == S_PAUSE);
            color_q     <= game_color;

            if (frame_tick) start_pend <= 1'b0;
            else if (btn_fall) start_pend <= 1'b1;

            if (frame_tick) over_pend <= 1'b0;
            else if (game_over && in_game) over_pend <= 1'b1;

            // Counter only moves on frames spent entirely in PLAY
            if (frame_tick) begin
                if (state_q == S_TITLE && state_d == S_PLAY)
                    tick_cnt <= '0;
                else if (stay_play)
                    tick_cnt <= (tick_cnt == TICK_LAST) ? '0 : tick_cnt + 1'b1;
            end

            if (frame_tick) begin
                if (state_q != S_OVER && state_d == S_OVER)
                    over_cnt <= '0;
                else if (state_q == S_OVER)
                    over_cnt <= (over_cnt == OVER_LAST) ? '0 : over_cnt + 1'b1;
            end
        end
    end

    assign game_tick  = frame_tick && stay_play && (tick_cnt == TICK_LAST);
    assign color_data = game_enable ? color_q : 2'b00;
    assign state      = state_q;

endmodule

// File: tb/tb_game_screen_controller.sv
// Directed self-checking bench for game_screen_controller.
// Pause sequence is exercised when GAME_PAUSE_EN is defined.
module tb_game_screen_controller;

    logic       clk = 1'b0;
    logic       KEY;
    logic [9:0] X;
    logic [9:0] Y;
    logic       start_btn;
    logic       game_over;
    logic [1:0] game_color;
    logic       game_enable;
    logic [1:0] color_data;
    logic       frame_tick;
    logic       game_tick;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;
    logic gt;

    game_screen_controller dut (
        .clock_25   (clk),
        .KEY        (KEY),
        .X          (X),
        .Y          (Y),
        .start_btn  (start_btn),
        .game_over  (game_over),
        .game_color (game_color),
        .game_enable(game_enable),
        .color_data (color_data),
        .frame_tick (frame_tick),
        .game_tick  (game_tick),
        .state      (state)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic boundary();
        X = 10'd639;
        Y = 10'd479;
        tick();
        X = 10'd0;
        Y = 10'd0;
    endtask

    task automatic frame(output logic g);
        boundary();
        check("frame_tick", 32'(frame_tick), 32'd1);
        g = game_tick;
        tick();
    endtask

    task automatic press();
        start_btn = 1'b0;
        repeat (4) tick();
        start_btn = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        KEY        = 1'b0;
        X          = 10'd300;
        Y          = 10'd200;
        start_btn  = 1'b1;
        game_over  = 1'b0;
        game_color = 2'b00;
        repeat (3) tick();
        check("rst_state", 32'(state), 32'd0);
        check("rst_ge", 32'(game_enable), 32'd0);
        check("rst_cd", 32'(color_data), 32'd0);
        check("rst_ft", 32'(frame_tick), 32'd0);
        check("rst_gt", 32'(game_tick), 32'd0);
        KEY = 1'b1;
        repeat (3) tick();

        // no press: boundary keeps TITLE
        frame(gt);
        check("idle_title", 32'(state), 32'd0);

        // press mid-frame, acted on only at boundary
        X = 10'd5;
        Y = 10'd100;
        game_color = 2'b10;
        press();
        repeat (20) tick();
        check("pend_title", 32'(state), 32'd0);
        check("title_cd", 32'(color_data), 32'd0);
        boundary();
        check("bnd_state", 32'(state), 32'd0);
        tick();
        check("play_state", 32'(state), 32'd1);
        check("play_ge", 32'(game_enable), 32'd1);
        check("play_cd", 32'(color_data), 32'd2);
        game_color = 2'b01;
        check("cd_hold", 32'(color_data), 32'd2);
        tick();
        check("cd_lat", 32'(color_data), 32'd1);

        // game_tick on every 8th frame
        for (int i = 0; i < 16; i++) begin
            frame(gt);
            check($sformatf("gt_%0d", i), 32'(gt), 32'((i % 8) == 7));
        end

        // bring counter to 7, then leave PLAY: no tick on exit frame
        for (int i = 0; i < 7; i++) frame(gt);
        game_over = 1'b1;
        tick();
        game_over = 1'b0;
        press();
        boundary();
        check("exit_gt", 32'(game_tick), 32'd0);
        check("exit_pre", 32'(state), 32'd1);
        tick();
        check("over_state", 32'(state), 32'd2);
        check("over_ge", 32'(game_enable), 32'd0);
        check("over_cd", 32'(color_data), 32'd0);
        for (int i = 0; i < 119; i++) begin
            if (i == 50) press();
            frame(gt);
        end
        check("over_119", 32'(state), 32'd2);
        frame(gt);
        check("over_done", 32'(state), 32'd0);
        frame(gt);
        check("over_press_drop", 32'(state), 32'd0);

        // re-entry zeroes the tick counter
        press();
        frame(gt);
        check("replay", 32'(state), 32'd1);
        for (int i = 0; i < 8; i++) begin
            frame(gt);
            check($sformatf("regt_%0d", i), 32'(gt), 32'(i == 7));
        end

`ifdef GAME_PAUSE_EN
        for (int i = 0; i < 3; i++) frame(gt);
        press();
        frame(gt);
        check("pause_gt", 32'(gt), 32'd0);
        check("pause_state", 32'(state), 32'd3);
        check("pause_ge", 32'(game_enable), 32'd1);
        for (int i = 0; i < 20; i++) begin
            frame(gt);
            check($sformatf("pgt_%0d", i), 32'(gt), 32'd0);
        end
        check("pause_hold", 32'(state), 32'd3);
        press();
        frame(gt);
        check("resume", 32'(state), 32'd1);
        for (int i = 0; i < 5; i++) begin
            frame(gt);
            check($sformatf("rgt_%0d", i), 32'(gt), 32'(i == 4));
        end
`else
        press();
        frame(gt);
        check("play_press_ign", 32'(state), 32'd1);
        frame(gt);
        check("play_pend_clr", 32'(state), 32'd1);
`endif

        // asynchronous reset mid-frame
        X = 10'd300;
        Y = 10'd200;
        game_color = 2'b11;
        tick();
        #3 KEY = 1'b0;
        #1;
        check("arst_state", 32'(state), 32'd0);
        check("arst_ge", 32'(game_enable), 32'd0);
        check("arst_cd", 32'(color_data), 32'd0);
        check("arst_gt", 32'(game_tick), 32'd0);
        tick();
        KEY = 1'b1;
        tick();
        frame(gt);
        check("arst_title", 32'(state), 32'd0);

        // long hold: exactly one event
        start_btn = 1'b0;
        repeat (200) tick();
        frame(gt);
        check("hold_play", 32'(state), 32'd1);
        repeat (300) tick();
        frame(gt);
        check("hold_once", 32'(state), 32'd1);
        repeat (500) tick();
        start_btn = 1'b1;
        repeat (4) tick();
        frame(gt);
        check("hold_rel", 32'(state), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
